pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised chain of pipeline registers that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffers of the pipelined datapath with one generic block. Each stage carries a valid bit and a W-bit payload. The payload holds whatever fields the datapath packs (pc, rs/rt data, imm, rd, ctrl). Unlike the existing free-running buffers, the block supports per-stage stall with bubble insertion, per-stage flush for taken branches and jumps, occupancy reporting and a retired-instruction counter.

## Interface
- W, default 32: payload width per stage, in bits.
- STAGES, default 4: number of pipeline registers, at least 2. Stage 0 is youngest (IF/ID). Stage STAGES-1 is oldest (MEM/WB).
- CNT_W, default 32: retire counter width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  producer (fetch) presents an instruction.
- in_data  in  W  payload loaded into stage 0.
- in_ready  out  1  stage 0 accepts in_data at this edge.
- stall  in  STAGES  stall[i] holds stage i and every younger stage.
- flush  in  STAGES  flush[i] invalidates stage i at the next edge.
- stage_valid  out  STAGES  valid bit of each stage register.
- stage_data  out  STAGES*W  flattened payloads; stage i occupies bits [i*W +: W].
- occupancy  out  $clog2(STAGES+1)  number of valid stages.
- retire_count  out  CNT_W  instructions that left stage STAGES-1.

## Operation
- Hold term: hold[i] = OR of stall[STAGES-1:i]. A stall at an older stage freezes all younger stages.
- Per-stage update at each rising edge. Priority is highest first:
  1. flush[i] sets valid to 0 and data to 0. Flush beats hold.
  2. hold[i] keeps valid and data.
  3. Stage 0 only: loads valid = in_valid, data = in_data.
  4. hold[i-1] is 1 while hold[i] is 0: inserts a bubble (valid 0, data 0).
  5. Otherwise: takes valid and data from stage i-1.
- in_ready = ~hold[0] & ~flush[0]. It is combinational. When in_valid is 1 and in_ready is 0, the producer must keep in_data stable. The block does not buffer it.
- Retire: when stage_valid[STAGES-1] is 1, hold[STAGES-1] is 0 and flush[STAGES-1] is 0, retire_count increments by 1 at the edge. It saturates at 2^CNT_W-1 and does not wrap.
- occupancy is a combinational popcount of stage_valid.
- Bubbles and flushed stages carry data 0. Downstream logic must gate every side effect with stage_valid.

## Timing
- Reset (rst_n low, asynchronous): stage_valid = 0, stage_data = 0, retire_count = 0. Consequently occupancy = 0 and in_ready = 1, provided stall and flush are 0.
- Deassertion of rst_n is synchronous to clk in the surrounding design. The first load happens at the first rising edge with rst_n high.
- Latency: a payload accepted at edge n is visible in stage i after edge n+i. It retires (counter updated) at edge n+STAGES, provided there are no stalls.
- Throughput: one instruction per cycle with no stall and no flush.
- stall and flush are sampled at the edge only. A flush lasting one cycle squashes exactly one cycle's contents of the flagged stages.
- Simultaneous flush[i] and stall[j] with j > i: stage i clears, stages older than i up to j hold, and stages younger than i hold. Stage j+1 gets a bubble.
- Reset asserted mid-stream: all in-flight instructions are lost immediately, not at the next edge, and the counter clears.

## Structure
- Package pipe_pkg holds the shared datapath constants: DATA_W = 32, REG_AW = 6, OPCODE_W = 4, CTRL_W = 12, and the control bit indices (ALUOP_HI = 11 … JUMP_MEM = 0). The datapath uses it to size W and pack the payloads.
- Sub-module pipe_stage_reg holds one valid+payload register with the priority logic above. It is instantiated STAGES times in a generate loop.
- The top level contains the hold prefix-OR, in_ready, the popcount and the saturating retire counter.

## Test plan
All scenarios use STAGES = 4 and W = 32.
- Reset: drive rst_n low with random inputs, then release. Required: stage_valid = 4'b0000, retire_count = 0, in_ready = 1, occupancy = 0.
- Streaming: accept 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive edges. Required: 0xA0 in stage 3 after edge 4, retire_count = 1 after edge 5 and 4 after edge 8, occupancy = 4 after edge 4.
- Stall with full pipe: stages 0–3 hold D, C, B, A; pulse stall = 4'b0010 for one cycle. Required: in_ready = 0 during the stall; after the edge, stage 0 = D, stage 1 = C, stage 2 is a bubble, stage 3 = B; retire_count +1 (A retired).
- Branch flush with full pipe: pulse flush = 4'b0011 with in_valid = 0. Required: after the edge, stage_valid = 4'b1100 with stages 2 and 3 advanced (stage 2 = C, stage 3 = B), and in_ready = 0 during the pulse.
- Flush beats hold: drive stall = 4'b0100 and flush = 4'b0100 together. Required: stage 2 is invalid with data 0, stages 0 and 1 unchanged, stage 3 gets a bubble.
- Asynchronous reset and counter saturation: assert rst_n mid-stream between edges. Required: all outputs clear within the same cycle. Separately, with CNT_W = 3, retire 9 instructions. Required: retire_count holds at 7.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared datapath constants and the per-stage update decision for pipe_stage_chain.
// The datapath packs its stage payloads using these field widths and control bit positions.
package pipe_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 6;
    localparam int OPCODE_W = 4;
    localparam int CTRL_W   = 12;

    localparam int ALUOP_HI   = 11;
    localparam int ALUOP_LO   = 8;
    localparam int REG_DST    = 7;
    localparam int ALU_SRC    = 6;
    localparam int MEM_TO_REG = 5;
    localparam int REG_WRITE  = 4;
    localparam int MEM_READ   = 3;
    localparam int MEM_WRITE  = 2;
    localparam int BRANCH     = 1;
    localparam int JUMP_MEM   = 0;

    typedef enum logic [2:0] {
        ACT_FLUSH,
        ACT_HOLD,
        ACT_LOAD,
        ACT_BUBBLE,
        ACT_SHIFT
    } stage_act_e;

    // Flush outranks hold, so a squashed stage clears even while frozen.
    function automatic stage_act_e stage_action(input logic flush, input logic hold,
                                                input logic hold_prev, input logic first);
        if (flush)     return ACT_FLUSH;
        if (hold)      return ACT_HOLD;
        if (first)     return ACT_LOAD;
        if (hold_prev) return ACT_BUBBLE;
        return ACT_SHIFT;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One valid+payload pipeline register with flush/hold/load/bubble/shift priority.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int W     = 32,
    parameter bit FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         hold_i,
    input  logic         hold_prev_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    stage_act_e   act;
    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    always_comb begin
        act     = stage_action(flush_i, hold_i, hold_prev_i, FIRST);
        valid_d = valid_q;
        data_d  = data_q;
        case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d = 1'b0;
                data_d  = '0;
            end
            ACT_HOLD: begin
                valid_d = valid_q;
                data_d  = data_q;
            end
            default: begin
                valid_d = valid_i;
                data_d  = data_i;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Generic pipeline-register chain: per-stage stall with bubble insertion, flush,
// occupancy popcount and a saturating retired-instruction counter.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [W-1:0]                in_data,
    output logic                        in_ready,
    input  logic [STAGES-1:0]           stall,
    input  logic [STAGES-1:0]           flush,
    output logic [STAGES-1:0]           stage_valid,
    output logic [STAGES*W-1:0]         stage_data,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [CNT_W-1:0]            retire_count
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0] hold;
    logic              retire_fire;
    logic [CNT_W-1:0]  retire_d, retire_q;

    // A stall at an older stage freezes everything younger than it.
    always_comb begin
        hold[STAGES-1] = stall[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
    end

    assign in_ready = ~hold[0] & ~flush[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic         vin;
        logic [W-1:0] din;
        logic         hprev;

        if (g == 0) begin : g_first
            assign vin   = in_valid;
            assign din   = in_data;
            assign hprev = 1'b0;
        end else begin : g_rest
            assign vin   = stage_valid[g-1];
            assign din   = stage_data[(g-1)*W +: W];
            assign hprev = hold[g-1];
        end

        pipe_stage_reg #(
            .W     (W),
            .FIRST (g == 0)
        ) u_reg (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (flush[g]),
            .hold_i      (hold[g]),
            .hold_prev_i (hprev),
            .valid_i     (vin),
            .data_i      (din),
            .valid_o     (stage_valid[g]),
            .data_o      (stage_data[g*W +: W])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(stage_valid[i]);
        end
    end

    assign retire_fire = stage_valid[STAGES-1] & ~hold[STAGES-1] & ~flush[STAGES-1];

    always_comb begin
        retire_d = retire_q;
        if (retire_fire && (retire_q != {CNT_W{1'b1}})) begin
            retire_d = retire_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: expected retirements are queued at issue
// and checked by a monitor; directed checks cover stall, flush, reset and saturation.
module tb_pipe_stage_chain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [3:0]  stall, flush;
    logic [3:0]  stage_valid;
    logic [127:0] stage_data;
    logic [2:0]  occupancy;
    logic [31:0] retire_count;

    logic        rst2_n;
    logic        in_valid2;
    logic [31:0] in_data2;
    logic        in_ready2;
    logic [3:0]  stall2, flush2;
    logic [3:0]  stage_valid2;
    logic [127:0] stage_data2;
    logic [2:0]  occupancy2;
    logic [2:0]  retire_count2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_chain #(.W(32), .STAGES(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall(stall), .flush(flush),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .occupancy(occupancy), .retire_count(retire_count)
    );

    pipe_stage_chain #(.W(32), .STAGES(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .stall(stall2), .flush(flush2),
        .stage_valid(stage_valid2), .stage_data(stage_data2),
        .occupancy(occupancy2), .retire_count(retire_count2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: an instruction leaving stage 3 at the coming edge must match the queue head.
    always @(negedge clk) begin
        if (rst_n && stage_valid[3] && !stall[3] && !flush[3]) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL retire_unexpected: got %0h, expected no retirement", stage_data[127:96]);
            end else begin
                chk("retire_data", {32'd0, stage_data[127:96]}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;  rst2_n = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; stall2 = '0; flush2 = '0;
        in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            in_data  = $urandom;
            stall    = 4'($urandom);
            flush    = 4'($urandom);
            step();
        end
        in_valid = 1'b0; stall = '0; flush = '0;
        #1;
        chk("rst_valid", 64'(stage_valid), 64'h0);
        chk("rst_data", 64'(stage_data[63:0] | stage_data[127:64]), 64'h0);
        chk("rst_count", 64'(retire_count), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        chk("rst_occ", 64'(occupancy), 64'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 64'(stage_valid), 64'h0);
        chk("post_rst_ready", 64'(in_ready), 64'h1);

        // Streaming A0..A3
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA0 + 32'(i);
            exp_q.push_back(in_data);
            step();
        end
        in_valid = 1'b0;
        chk("stream_st3", 64'(stage_data[127:96]), 64'hA0);
        chk("stream_st0", 64'(stage_data[31:0]), 64'hA3);
        chk("stream_occ", 64'(occupancy), 64'h4);
        step();
        chk("stream_cnt5", 64'(retire_count), 64'h1);
        step(); step(); step();
        chk("stream_cnt8", 64'(retire_count), 64'h4);
        chk("stream_empty", 64'(stage_valid), 64'h0);

        // Stall at stage 1 with full pipe
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'h11 * 32'(i);
            exp_q.push_back(in_data);
            step();
        end
        in_valid = 1'b0;
        stall = 4'b0010;
        #1;
        chk("stall_ready", 64'(in_ready), 64'h0);
        step();
        stall = '0;
        chk("stall_valid", 64'(stage_valid), 64'hB);
        chk("stall_st0", 64'(stage_data[31:0]), 64'h44);
        chk("stall_st1", 64'(stage_data[63:32]), 64'h33);
        chk("stall_st2", 64'(stage_data[95:64]), 64'h0);
        chk("stall_st3", 64'(stage_data[127:96]), 64'h22);
        chk("stall_cnt", 64'(retire_count), 64'h5);
        for (int i = 0; i < 4; i++) step();
        chk("stall_drain_cnt", 64'(retire_count), 64'h8);

        // Branch flush of stages 0 and 1
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'h60 + 32'(i);
            if (i != 4) exp_q.push_back(in_data);
            step();
        end
        in_valid = 1'b0;
        flush = 4'b0011;
        #1;
        chk("flush_ready", 64'(in_ready), 64'h0);
        step();
        flush = '0;
        chk("flush_valid", 64'(stage_valid), 64'hC);
        chk("flush_st2", 64'(stage_data[95:64]), 64'h63);
        chk("flush_st3", 64'(stage_data[127:96]), 64'h62);
        chk("flush_low_data", 64'(stage_data[63:0]), 64'h0);
        chk("flush_cnt", 64'(retire_count), 64'h9);

        // Flush beats hold at stage 2
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 32'h70 + 32'(i);
            if (i != 2) exp_q.push_back(in_data);
            step();
        end
        in_valid = 1'b0;
        chk("refill_cnt", 64'(retire_count), 64'd11);
        stall = 4'b0100;
        flush = 4'b0100;
        #1;
        chk("fbh_ready", 64'(in_ready), 64'h0);
        step();
        stall = '0; flush = '0;
        chk("fbh_valid", 64'(stage_valid), 64'h3);
        chk("fbh_st0", 64'(stage_data[31:0]), 64'h74);
        chk("fbh_st1", 64'(stage_data[63:32]), 64'h73);
        chk("fbh_st2", 64'(stage_data[95:64]), 64'h0);
        chk("fbh_st3", 64'(stage_data[127:96]), 64'h0);
        chk("fbh_cnt", 64'(retire_count), 64'd12);
        for (int i = 0; i < 4; i++) step();
        chk("fbh_drain_cnt", 64'(retire_count), 64'd14);

        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        in_data = 32'h81; step();
        in_data = 32'h82; step();
        in_valid = 1'b0;
        chk("pre_arst_occ", 64'(occupancy), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(stage_valid), 64'h0);
        chk("arst_data", 64'(stage_data[63:0] | stage_data[127:64]), 64'h0);
        chk("arst_cnt", 64'(retire_count), 64'h0);
        chk("arst_occ", 64'(occupancy), 64'h0);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        step();
        rst_n = 1'b1;

        // Counter saturation with CNT_W = 3
        rst2_n = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            in_valid2 = (e <= 9);
            in_data2  = 32'(e);
            step();
            if (e == 10) chk("sat_cnt_e10", 64'(retire_count2), 64'd6);
            if (e == 11) chk("sat_cnt_e11", 64'(retire_count2), 64'd7);
            if (e == 13) chk("sat_cnt_e13", 64'(retire_count2), 64'd7);
        end
        in_valid2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
